// File: rtl/axi_traffic_gen.sv
// AXI write-then-read traffic generator: writes seed+k as one INCR burst, reads it
// back and reports data mismatches, ID/RLAST protocol errors and watchdog expiry.
package axi_tg_pkg;

  typedef struct packed {
    logic [3:0]  aw_id;
    logic [15:0] aw_addr;
    logic [7:0]  aw_len;
    logic [2:0]  aw_size;
    logic [1:0]  aw_burst;
    logic        aw_valid;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        w_last;
    logic        w_valid;
    logic        b_ready;
    logic [3:0]  ar_id;
    logic [15:0] ar_addr;
    logic [7:0]  ar_len;
    logic [2:0]  ar_size;
    logic [1:0]  ar_burst;
    logic        ar_valid;
    logic        r_ready;
  } axi_mosi_t;

  typedef struct packed {
    logic        aw_ready;
    logic        w_ready;
    logic [3:0]  b_id;
    logic        b_valid;
    logic        ar_ready;
    logic [3:0]  r_id;
    logic [31:0] r_data;
    logic        r_last;
    logic        r_valid;
  } axi_miso_t;

endpackage

module axi_traffic_gen
  import axi_tg_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic [15:0] base_addr_i,
  input  logic [7:0]  len_i,
  input  logic [3:0]  id_i,
  input  logic [31:0] seed_i,
  output axi_mosi_t   m_axi_o,
  input  axi_miso_t   m_axi_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] err_cnt_o,
  output logic        id_err_o,
  output logic        last_err_o,
  output logic        timeout_o
);

  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE
  } state_t;

  state_t          state, state_next;
  logic [15:0]     base;
  logic [7:0]      len;
  logic [3:0]      id;
  logic [31:0]     seed;
  logic [7:0]      beat;
  logic [WD_W-1:0] wd;

  logic        hs;
  logic        in_phase;
  logic        wd_hit;
  logic        last_beat;
  logic [31:0] expect_data;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_next  = state;
    m_axi_o     = '0;
    hs          = 1'b0;
    in_phase    = 1'b0;
    expect_data = seed + 32'(beat);
    last_beat   = (beat == len);

    unique case (state)
      S_IDLE: if (start_i) state_next = S_AW;
      S_AW: begin
        in_phase          = 1'b1;
        m_axi_o.aw_valid  = 1'b1;
        m_axi_o.aw_id     = id;
        m_axi_o.aw_addr   = base;
        m_axi_o.aw_len    = len;
        m_axi_o.aw_size   = 3'b010;
        m_axi_o.aw_burst  = 2'b01;
        hs                = m_axi_i.aw_ready;
        if (hs) state_next = S_W;
      end
      S_W: begin
        in_phase        = 1'b1;
        m_axi_o.w_valid = 1'b1;
        m_axi_o.w_data  = expect_data;
        m_axi_o.w_strb  = 4'hF;
        m_axi_o.w_last  = last_beat;
        hs              = m_axi_i.w_ready;
        if (hs && last_beat) state_next = S_B;
      end
      S_B: begin
        in_phase        = 1'b1;
        m_axi_o.b_ready = 1'b1;
        hs              = m_axi_i.b_valid;
        if (hs) state_next = S_AR;
      end
      S_AR: begin
        in_phase          = 1'b1;
        m_axi_o.ar_valid  = 1'b1;
        m_axi_o.ar_id     = id;
        m_axi_o.ar_addr   = base;
        m_axi_o.ar_len    = len;
        m_axi_o.ar_size   = 3'b010;
        m_axi_o.ar_burst  = 2'b01;
        hs                = m_axi_i.ar_ready;
        if (hs) state_next = S_R;
      end
      S_R: begin
        in_phase        = 1'b1;
        m_axi_o.r_ready = 1'b1;
        hs              = m_axi_i.r_valid;
        // Any RLAST, or the final expected beat, closes the read phase.
        if (hs && (m_axi_i.r_last || last_beat)) state_next = S_DONE;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase

    // The watchdog expires on the cycle that would be the TIMEOUT-th without a handshake.
    wd_hit = in_phase && !hs && (wd == WD_W'(TIMEOUT - 1));
    if (wd_hit) state_next = S_DONE;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= S_IDLE;
      base       <= '0;
      len        <= '0;
      id         <= '0;
      seed       <= '0;
      beat       <= '0;
      wd         <= '0;
      err_cnt_o  <= '0;
      id_err_o   <= 1'b0;
      last_err_o <= 1'b0;
      timeout_o  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state <= state_next;

      if (state == S_IDLE && start_i) begin
        base       <= base_addr_i;
        len        <= len_i;
        id         <= id_i;
        seed       <= seed_i;
        err_cnt_o  <= '0;
        id_err_o   <= 1'b0;
        last_err_o <= 1'b0;
        timeout_o  <= 1'b0;
      end

      if (!in_phase || hs) wd <= '0;
      else                 wd <= wd + WD_W'(1);

      if (state_next != state)                        beat <= '0;
      else if (hs && (state == S_W || state == S_R)) beat <= beat + 8'd1;

      if (state == S_B && hs && m_axi_i.b_id != id) id_err_o <= 1'b1;

      if (state == S_R && hs) begin
        if (m_axi_i.r_data != expect_data && err_cnt_o != 16'hFFFF)
          err_cnt_o <= err_cnt_o + 16'd1;
        if (m_axi_i.r_id != id)            id_err_o   <= 1'b1;
        if (m_axi_i.r_last != last_beat)   last_err_o <= 1'b1;
      end

      if (wd_hit) timeout_o <= 1'b1;
    end
  end

  assign busy_o = (state != S_IDLE);
  assign done_o = (state == S_DONE);

endmodule

// File: tb/tb_axi_traffic_gen.sv
// Bench for axi_traffic_gen: a randomized responder drives the slave side while a
// transaction-level model predicts every output on every cycle.
module tb_axi_traffic_gen;
  import axi_tg_pkg::*;

  localparam int TO = 16;

  typedef enum int {P_IDLE, P_AW, P_W, P_B, P_AR, P_R, P_DONE} phase_t;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        start     = 1'b0;
  logic [15:0] base_addr = '0;
  logic [7:0]  len       = '0;
  logic [3:0]  id        = '0;
  logic [31:0] seed      = '0;
  axi_mosi_t   mosi;
  axi_miso_t   miso      = '0;
  logic        busy, done, id_err, last_err, timeout;
  logic [15:0] err_cnt;

  axi_traffic_gen #(.TIMEOUT(TO)) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .start_i    (start),
    .base_addr_i(base_addr),
    .len_i      (len),
    .id_i       (id),
    .seed_i     (seed),
    .m_axi_o    (mosi),
    .m_axi_i    (miso),
    .busy_o     (busy),
    .done_o     (done),
    .err_cnt_o  (err_cnt),
    .id_err_o   (id_err),
    .last_err_o (last_err),
    .timeout_o  (timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Responder script for the current test.
  int          cfg_stall   = 0;
  bit          cfg_aw_hang = 1'b0;
  logic [3:0]  cfg_bid     = '0;
  int          cfg_rid_bad = -1;
  int          cfg_rlast   = 0;
  logic [31:0] rscript [256];

  // Transaction-level model state.
  phase_t      ph        = P_IDLE;
  int          k         = 0;
  int          wd        = 0;
  int          stall_run = 0;
  logic [15:0] m_base    = '0;
  logic [7:0]  m_len     = '0;
  logic [3:0]  m_id      = '0;
  logic [31:0] m_seed    = '0;
  int          exp_err   = 0;
  bit          exp_id    = 1'b0;
  bit          exp_last  = 1'b0;
  bit          exp_to    = 1'b0;
  int          dut_done  = 0;
  int          done_cyc  = 0;
  int          aw_rise_cyc = 0;
  int          r_end_cyc = 0;
  logic [31:0] w_log [256];
  bit          wlast_log [256];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic axi_mosi_t model_mosi();
    axi_mosi_t m;
    m = '0;
    case (ph)
      P_AW: begin
        m.aw_valid = 1'b1; m.aw_id = m_id; m.aw_addr = m_base;
        m.aw_len = m_len; m.aw_size = 3'b010; m.aw_burst = 2'b01;
      end
      P_W: begin
        m.w_valid = 1'b1; m.w_data = m_seed + 32'(k);
        m.w_strb = 4'hF; m.w_last = (k == int'(m_len));
      end
      P_B: m.b_ready = 1'b1;
      P_AR: begin
        m.ar_valid = 1'b1; m.ar_id = m_id; m.ar_addr = m_base;
        m.ar_len = m_len; m.ar_size = 3'b010; m.ar_burst = 2'b01;
      end
      P_R: m.r_ready = 1'b1;
      default: m = '0;
    endcase
    return m;
  endfunction

  // Pick this cycle's responder inputs and advance the model by the resulting handshake.
  task automatic step();
    logic   go, hs;
    phase_t was;
    go   = (stall_run >= 4) || ($urandom_range(99) >= cfg_stall);
    hs   = 1'b0;
    was  = ph;
    miso = '0;
    case (ph)
      P_IDLE: if (start) begin
        m_base = base_addr; m_len = len; m_id = id; m_seed = seed;
        exp_err = 0; exp_id = 1'b0; exp_last = 1'b0; exp_to = 1'b0;
        wd = 0; ph = P_AW; aw_rise_cyc = cyc + 1;
      end
      P_AW: begin
        miso.aw_ready = go && !cfg_aw_hang;
        hs = miso.aw_ready;
        if (hs) begin ph = P_W; k = 0; end
      end
      P_W: begin
        miso.w_ready = go;
        hs = go;
        if (hs) begin
          w_log[k] = mosi.w_data;
          wlast_log[k] = mosi.w_last;
          if (k == int'(m_len)) ph = P_B;
          else k++;
        end
      end
      P_B: begin
        miso.b_valid = go;
        miso.b_id = cfg_bid;
        hs = go;
        if (hs) begin
          if (cfg_bid != m_id) exp_id = 1'b1;
          ph = P_AR;
        end
      end
      P_AR: begin
        miso.ar_ready = go;
        hs = go;
        if (hs) begin ph = P_R; k = 0; end
      end
      P_R: begin
        miso.r_valid = go;
        miso.r_data  = rscript[k];
        miso.r_id    = (k == cfg_rid_bad) ? ~m_id : m_id;
        miso.r_last  = (k == cfg_rlast);
        hs = go;
        if (hs) begin
          if (miso.r_data != m_seed + 32'(k) && exp_err < 65535) exp_err++;
          if (miso.r_id != m_id) exp_id = 1'b1;
          if (miso.r_last && k < int'(m_len)) exp_last = 1'b1;
          if (!miso.r_last && k == int'(m_len)) exp_last = 1'b1;
          if (miso.r_last || k == int'(m_len)) begin
            ph = P_DONE; r_end_cyc = cyc;
          end else k++;
        end
      end
      P_DONE: begin done_cyc = cyc; ph = P_IDLE; end
      default: ph = P_IDLE;
    endcase
    if (was inside {P_AW, P_W, P_B, P_AR, P_R}) begin
      if (hs) wd = 0;
      else begin
        wd++;
        if (wd == TO) begin ph = P_DONE; exp_to = 1'b1; wd = 0; end
      end
    end
    stall_run = go ? 0 : stall_run + 1;
  endtask

  // Compare process: every cycle, away from the rising edge.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      ph = P_IDLE; k = 0; wd = 0;
      exp_err = 0; exp_id = 1'b0; exp_last = 1'b0; exp_to = 1'b0;
    end
    if (done) dut_done++;
    check("mosi",     128'(mosi),     128'(model_mosi()));
    check("busy",     128'(busy),     128'(ph != P_IDLE));
    check("done",     128'(done),     128'(ph == P_DONE));
    check("err_cnt",  128'(err_cnt),  128'(exp_err));
    check("id_err",   128'(id_err),   128'(exp_id));
    check("last_err", 128'(last_err), 128'(exp_last));
    check("timeout",  128'(timeout),  128'(exp_to));
    if (rst_n) step();
    else miso = '0;
  end

  task automatic setup(input logic [15:0] b, input logic [7:0] l, input logic [3:0] i,
                       input logic [31:0] s);
    base_addr   = b;
    len         = l;
    id          = i;
    seed        = s;
    cfg_stall   = 0;
    cfg_aw_hang = 1'b0;
    cfg_bid     = i;
    cfg_rid_bad = -1;
    cfg_rlast   = int'(l);
    for (int n = 0; n < 256; n++) rscript[n] = s + 32'(n);
  endtask

  task automatic wait_done(input int d0, input int budget);
    int i;
    i = 0;
    while (dut_done == d0 && i < budget) begin
      @(posedge clk);
      i++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("done_pulses", 128'(dut_done - d0), 128'(1));
  endtask

  task automatic run_test(input int budget);
    int d0;
    d0 = dut_done;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(d0, budget);
  endtask

  initial begin
    int d0;
    bit found;

    // Always-ready responder; start is already high when reset releases.
    setup(16'h0100, 8'd3, 4'h5, 32'hA000_0000);
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    d0 = dut_done;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(d0, 200);
    check("t1_w0",     128'(w_log[0]),     128'(32'hA000_0000));
    check("t1_w3",     128'(w_log[3]),     128'(32'hA000_0003));
    check("t1_wlast3", 128'(wlast_log[3]), 128'(1));
    check("t1_wlast2", 128'(wlast_log[2]), 128'(0));
    check("t1_err",    128'(err_cnt),      128'(0));
    check("t1_flags",  128'({id_err, last_err, timeout}), 128'(0));

    // One corrupted read beat.
    setup(16'h0100, 8'd3, 4'h5, 32'hA000_0000);
    rscript[2] = 32'hDEAD_BEEF;
    run_test(200);
    check("t2_err",  128'(err_cnt),  128'(1));
    check("t2_last", 128'(last_err), 128'(0));

    // Long burst under backpressure; the pattern wraps through zero.
    setup(16'h2000, 8'd255, 4'hA, 32'hFFFF_FFFE);
    cfg_stall = 40;
    run_test(4000);
    check("t3_w1",     128'(w_log[1]),       128'(32'hFFFF_FFFF));
    check("t3_w2",     128'(w_log[2]),       128'(32'h0000_0000));
    check("t3_wlast",  128'(wlast_log[255]), 128'(1));
    check("t3_err",    128'(err_cnt),        128'(0));
    check("t3_flags",  128'({id_err, last_err, timeout}), 128'(0));

    // AWREADY never arrives: the watchdog must end the test.
    setup(16'h0300, 8'd3, 4'h3, 32'h0000_1234);
    cfg_aw_hang = 1'b1;
    run_test(200);
    check("t4_timeout", 128'(timeout),                128'(1));
    check("t4_delay",   128'(done_cyc - aw_rise_cyc), 128'(16));
    check("t4_idle",    128'(busy),                   128'(0));
    cfg_aw_hang = 1'b0;

    // Early RLAST on beat 1.
    setup(16'h0500, 8'd3, 4'h9, 32'h1234_5678);
    cfg_rlast = 1;
    run_test(200);
    check("t5_last",  128'(last_err),             128'(1));
    check("t5_delay", 128'(done_cyc - r_end_cyc), 128'(1));
    check("t5_err",   128'(err_cnt),              128'(0));

    // Reset in the middle of the write burst, then a clean rerun.
    setup(16'h0400, 8'd3, 4'h7, 32'h5555_0000);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(posedge clk); #1;
      if (mosi.w_valid && mosi.w_data == seed + 32'd2) found = 1'b1;
    end
    check("t6_beat2", 128'(found), 128'(1));
    rst_n = 1'b0;
    #1;
    check("t6_wvalid", 128'(mosi.w_valid), 128'(0));
    check("t6_busy",   128'(busy),         128'(0));
    check("t6_mosi",   128'(mosi),         128'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    run_test(200);
    check("t6_w3",    128'(w_log[3]), 128'(32'h5555_0003));
    check("t6_err",   128'(err_cnt),  128'(0));
    check("t6_flags", 128'({id_err, last_err, timeout}), 128'(0));

    // Randomized tests with backpressure and injected faults from the responder.
    for (int t = 0; t < 12; t++) begin
      setup(16'($urandom), (t == 0) ? 8'd0 : 8'($urandom_range(20)), 4'($urandom), $urandom);
      cfg_stall = int'($urandom_range(50));
      if ($urandom_range(3) == 0) cfg_bid = ~id;
      if ($urandom_range(4) == 0) cfg_rid_bad = int'($urandom_range(int'(len)));
      for (int b = 0; b <= int'(len); b++)
        if ($urandom_range(5) == 0) rscript[b] = ~rscript[b];
      if ($urandom_range(3) == 0) cfg_rlast = int'($urandom_range(int'(len) + 1));
      run_test(int'(len) * 8 + 200);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not complete, limit 1000000 time units");
    $fatal(1);
  end

endmodule

// File: doc/axi_traffic_gen.md
AXI_TRAFFIC_GEN -- requirements
Module: axi_traffic_gen

Interface
REQ-001 Parameter TIMEOUT, default 1024, shall set the watchdog limit in cycles without any handshake.
REQ-002 clk_i  input  1  clock; all logic shall be on the rising edge.
REQ-003 rst_n_i  input  1  reset; asynchronous, active-low.
REQ-004 start_i  input  1  one-cycle request to run one write-then-read test.
REQ-005 base_addr_i  input  16  burst start address.
REQ-006 len_i  input  8  AXI burst length (beats minus 1).
REQ-007 id_i  input  4  transaction ID for AW and AR.
REQ-008 seed_i  input  32  data pattern seed.
REQ-009 m_axi_o  output  axi_mosi_t  AXI master request channels (AW, W, AR, BREADY, RREADY).
REQ-010 m_axi_i  input  axi_miso_t  AXI responder channels (AWREADY, WREADY, B, ARREADY, R).
REQ-011 busy_o  output  1  high in every state except IDLE.
REQ-012 done_o  output  1  one-cycle pulse at the end of a test.
REQ-013 err_cnt_o  output  16  saturating count of read-data mismatches in the last test.
REQ-014 id_err_o, last_err_o, timeout_o  output  1 each  sticky error flags for the last test.

Function
REQ-015 FSM states shall be IDLE, AW, W, B, AR, R, DONE, visited in that order.
REQ-016 In IDLE, start_i=1 shall latch base, len, id and seed, clear err_cnt_o and all error flags, and move to AW.
REQ-017 start_i outside IDLE shall be ignored.
REQ-018 AW: AWVALID=1 with AWID=id, AWADDR=base, AWLEN=len, AWSIZE=3'b010, AWBURST=2'b01; fields stable until AWREADY.
REQ-019 The AWVALID&AWREADY cycle shall move the FSM to W; AW and W shall never overlap.
REQ-020 W: beat k (0..len) shall carry WDATA=seed+k (mod 2^32), WSTRB=4'hF, WLAST=(k==len).
REQ-021 W: WVALID shall stay high until the handshake on beat len; the beat counter advances only on WVALID&WREADY.
REQ-022 B: BREADY=1; BVALID shall move the FSM to AR; BID!=id shall set id_err_o.
REQ-023 AR: same field rules as AW on the AR channel; the ARVALID&ARREADY cycle moves to R.
REQ-024 R: RREADY=1; each RVALID beat k shall compare RDATA against seed+k and increment err_cnt_o on mismatch.
REQ-025 err_cnt_o shall saturate at 16'hFFFF.
REQ-026 R: RID!=id shall set id_err_o.
REQ-027 RLAST=1 with k<len shall set last_err_o and end the read phase.
REQ-028 RLAST=0 on beat len shall set last_err_o and end the read phase.
REQ-029 A correct RLAST on beat len shall end the read phase normally; any end of the read phase moves to DONE.
REQ-030 DONE shall last one cycle, assert done_o, and return to IDLE.
REQ-031 Watchdog: a counter in states AW..R shall clear on any handshake.
REQ-032 Watchdog reaching TIMEOUT shall set timeout_o, drop all VALID/READY outputs, and go to DONE.
REQ-033 All unused m_axi_o fields shall be 0; VALID signals shall be 0 in states other than their own channel's state.

Reset
REQ-034 rst_n_i=0 shall immediately force IDLE and drive all m_axi_o fields to 0.
REQ-035 rst_n_i=0 shall also force busy_o=0, done_o=0, err_cnt_o=0, all flags=0 and clear all counters, including mid-burst.
REQ-036 The first start_i shall be accepted on the first rising edge with rst_n_i=1.

Verification
REQ-037 Always-ready responder, base=16'h0100, len=3, id=4'h5, seed=32'hA000_0000 -> W data A0000000..A0000003, WLAST on 4th beat, err_cnt_o=0, all flags 0, one done_o pulse.
REQ-038 Responder returns beat 2 as 32'hDEAD_BEEF, len=3 -> err_cnt_o=1, last_err_o=0.
REQ-039 Random WREADY/RREADY backpressure, len=255, seed=32'hFFFF_FFFE -> beat 2 data wraps to 32'h0000_0000, no errors, AW/W fields stable while stalled.
REQ-040 AWREADY held low, TIMEOUT=16 -> timeout_o=1 and done_o exactly 16 cycles after AWVALID rises, then IDLE.
REQ-041 Responder sends RLAST on beat 1 with len=3 -> last_err_o=1, DONE next cycle.
REQ-042 rst_n_i pulsed low during W beat 2 -> WVALID=0 in the same cycle, busy_o=0, a subsequent start_i runs normally.
